// File: rtl/tl_c_insight_tracer.sv
// Passive TileLink C-channel monitor: assembles beats into records and queues them in a trace FIFO.
// Optional first-beat timestamp capture is enabled by defining TL_C_INSIGHT_TS_EN.
module tl_c_insight_tracer #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SOURCE_W = 3,
    parameter int unsigned SIZE_W   = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TS_W     = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                c_valid,
    input  logic                c_ready,
    input  logic [2:0]          c_opcode,
    input  logic [2:0]          c_param,
    input  logic [SIZE_W-1:0]   c_size,
    input  logic [SOURCE_W-1:0] c_source,
    input  logic [ADDR_W-1:0]   c_address,
    input  logic                c_corrupt,
    input  logic                enable,
    input  logic                clear,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [2:0]          rec_opcode,
    output logic [2:0]          rec_param,
    output logic [SIZE_W-1:0]   rec_size,
    output logic [SOURCE_W-1:0] rec_source,
    output logic [ADDR_W-1:0]   rec_address,
    output logic                rec_corrupt,
    output logic [TS_W-1:0]     rec_ts,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overflow,
    output logic                proto_err
);

    localparam int unsigned BEAT_LOG2 = $clog2(DATA_W / 8);
    localparam int unsigned REM_W     = 1 << SIZE_W;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CW        = PTR_W + 1;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic                corrupt;
`ifdef TL_C_INSIGHT_TS_EN
        logic [TS_W-1:0]     ts;
`endif
    } rec_t;

    typedef enum logic [1:0] {IDLE, BURST, EMIT} state_t;

    state_t           state, state_nxt;
    rec_t             beat, hdr;
    logic             cap;
    logic [REM_W-1:0] remaining, first_rem;
    logic             fire, first_beat, multi, hdr_diff, push;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop, do_push, drop;

`ifdef TL_C_INSIGHT_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + TS_W'(1);
    end
`endif

    always_comb begin
        beat         = '0;
        beat.opcode  = c_opcode;
        beat.param   = c_param;
        beat.size    = c_size;
        beat.source  = c_source;
        beat.address = c_address;
        beat.corrupt = c_corrupt;
`ifdef TL_C_INSIGHT_TS_EN
        beat.ts      = ts_cnt;
`endif
    end

    assign fire       = c_valid & c_ready;
    // A fire in EMIT is a new message's first beat, so only BURST consumes continuation beats.
    assign first_beat = fire && (state != BURST);
    assign multi      = c_opcode[0] && (c_size > SIZE_W'(BEAT_LOG2));
    assign first_rem  = (REM_W'(1) << (c_size - SIZE_W'(BEAT_LOG2))) - REM_W'(1);
    assign hdr_diff   = (c_opcode != hdr.opcode) || (c_param != hdr.param) ||
                        (c_size != hdr.size) || (c_source != hdr.source) ||
                        (c_address != hdr.address);
    assign push       = (state == EMIT) && cap;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, EMIT: begin
                if (first_beat) state_nxt = multi ? BURST : EMIT;
                else            state_nxt = IDLE;
            end
            BURST: begin
                if (fire && (remaining == REM_W'(1))) state_nxt = EMIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hdr       <= '0;
            cap       <= 1'b0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (first_beat) begin
                hdr       <= beat;
                cap       <= enable;
                remaining <= first_rem;
            end else if ((state == BURST) && fire) begin
                remaining   <= remaining - REM_W'(1);
                hdr.corrupt <= hdr.corrupt | c_corrupt;
            end
        end
    end

    always_comb begin
        pop     = (count != '0) && rec_ready;
        do_push = push && ((count != CW'(DEPTH)) || pop);
        drop    = push && !do_push;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            proto_err  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= hdr;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            end
            if ((state == BURST) && fire && hdr_diff) proto_err <= 1'b1;
        end
    end

    assign rec_valid   = (count != '0);
    assign rec_opcode  = mem[rd_ptr].opcode;
    assign rec_param   = mem[rd_ptr].param;
    assign rec_size    = mem[rd_ptr].size;
    assign rec_source  = mem[rd_ptr].source;
    assign rec_address = mem[rd_ptr].address;
    assign rec_corrupt = mem[rd_ptr].corrupt;
`ifdef TL_C_INSIGHT_TS_EN
    assign rec_ts      = mem[rd_ptr].ts;
`else
    assign rec_ts      = '0;
`endif

endmodule

// File: tb/tb_tl_c_insight_tracer.sv
// Randomised self-checking bench for tl_c_insight_tracer against a message-level reference model.
module tb_tl_c_insight_tracer;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int SOURCE_W = 3;
    localparam int SIZE_W   = 4;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 16;
    localparam int TS_W     = 32;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                c_valid = 1'b0, c_ready = 1'b0, c_corrupt = 1'b0;
    logic [2:0]          c_opcode = '0, c_param = '0;
    logic [SIZE_W-1:0]   c_size = '0;
    logic [SOURCE_W-1:0] c_source = '0;
    logic [ADDR_W-1:0]   c_address = '0;
    logic                enable = 1'b1, clear = 1'b0, rec_ready = 1'b0;
    logic                rec_valid, rec_corrupt, overflow, proto_err;
    logic [2:0]          rec_opcode, rec_param;
    logic [SIZE_W-1:0]   rec_size;
    logic [SOURCE_W-1:0] rec_source;
    logic [ADDR_W-1:0]   rec_address;
    logic [TS_W-1:0]     rec_ts;
    logic [CNT_W-1:0]    drop_count;

    tl_c_insight_tracer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W),
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_corrupt(c_corrupt),
        .enable(enable), .clear(clear),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_opcode(rec_opcode),
        .rec_param(rec_param), .rec_size(rec_size), .rec_source(rec_source),
        .rec_address(rec_address), .rec_corrupt(rec_corrupt), .rec_ts(rec_ts),
        .drop_count(drop_count), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic                corrupt;
    } rec_t;

    rec_t            exp_q[$];
    rec_t            got_q[$];
    logic [TS_W-1:0] got_ts[$];
    int unsigned     m_drop = 0;
    logic            m_overflow = 1'b0, m_proto = 1'b0;
    int              checks = 0, failures = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int unsigned beats_of(input logic [2:0] op, input logic [SIZE_W-1:0] sz);
        int unsigned bytes = 1 << sz;
        if (op[0] && (bytes > DATA_W / 8)) return bytes / (DATA_W / 8);
        return 1;
    endfunction

    task automatic idle_garbage();
        c_valid   = 1'($urandom_range(0, 1));
        c_ready   = c_valid ? 1'b0 : 1'($urandom_range(0, 1));
        c_opcode  = 3'($urandom);
        c_param   = 3'($urandom);
        c_size    = SIZE_W'($urandom);
        c_source  = SOURCE_W'($urandom);
        c_address = ADDR_W'($urandom);
        c_corrupt = 1'($urandom);
        tick();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drop = 0;
        m_overflow = 1'b0;
        m_proto = 1'b0;
    endtask

    task automatic model_push(input rec_t r);
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else begin
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
            m_overflow = 1'b1;
        end
    endtask

    // One whole message; returns with the last beat just fired (the record is about to be pushed).
    task automatic send_msg(input logic [2:0] op, input logic [2:0] prm, input logic [SIZE_W-1:0] sz,
                            input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] cmask, input logic en_first, input logic en_rest,
                            input int bad_beat, input int clr_beat, input int stall_pct);
        int unsigned n = beats_of(op, sz);
        logic cor = 1'b0;
        for (int unsigned b = 0; b < n; b++) begin
            enable = (b == 0) ? en_first : en_rest;
            while ($urandom_range(0, 99) < stall_pct) idle_garbage();
            c_valid   = 1'b1;
            c_ready   = 1'b1;
            c_opcode  = op;
            c_param   = prm;
            c_size    = sz;
            c_source  = src;
            c_address = (int'(b) == bad_beat) ? (addr ^ 32'h40) : addr;
            c_corrupt = cmask[b];
            cor       = cor | cmask[b];
            clear     = (int'(b) == clr_beat);
            if (clear) model_reset();
            tick();
            clear = 1'b0;
        end
        c_valid = 1'b0;
        c_ready = 1'b0;
        if (bad_beat > 0 && bad_beat < int'(n)) m_proto = 1'b1;
        if (en_first) model_push({op, prm, sz, src, addr, cor});
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        tick();
        tick();
        got_q.delete();
        got_ts.delete();
        rec_ready = 1'b1;
        for (int unsigned i = 0; i < DEPTH * 3 + 4; i++) begin
            if (rec_valid === 1'b1) begin
                got_q.push_back({rec_opcode, rec_param, rec_size, rec_source, rec_address, rec_corrupt});
                got_ts.push_back(rec_ts);
            end
            tick();
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL reset_rec_valid got=%b exp=0", rec_valid); end
        checks++; if (drop_count !== '0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if ({overflow, proto_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, proto_err); end
        checks++; if ({rec_address, rec_ts} !== '0) begin failures++; $display("FAIL reset_fields got=%h/%h exp=0", rec_address, rec_ts); end
        reset_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single_beat();
        send_msg(3'd4, 3'd0, 4'd6, 3'd2, 32'h8000_1000, 0, 1'b1, 1'b1, -1, -1, 0);
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL single_lat_n1 got=%b exp=0", rec_valid); end
        tick();
        checks++; if (rec_valid !== 1'b1) begin failures++; $display("FAIL single_lat_n2 got=%b exp=1", rec_valid); end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_burst();
        send_msg(3'd7, 3'd1, 4'd6, 3'd5, 32'h0000_2040, 32'h10, 1'b1, 1'b1, -1, -1, 25);
        send_msg(3'd7, 3'd2, 4'd6, 3'd1, 32'h0000_3000, 32'h80, 1'b1, 1'b1, -1, -1, 25);
        send_msg(3'd5, 3'd0, 4'd5, 3'd3, 32'h0000_4000, 32'h0, 1'b1, 1'b1, -1, -1, 25);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL burst_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] addr = ADDR_W'($urandom);
        enable = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < int'($urandom_range(1, 3)); s++) begin
                c_valid = 1'b1; c_ready = 1'b0;
                c_opcode = 3'd7; c_param = 3'd0; c_size = 4'd6; c_source = 3'd4; c_address = addr;
                c_corrupt = 1'b1;
                tick();
            end
            if (b == 7) begin
                checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL bp_early got=%b exp=0", rec_valid); end
            end
            c_ready = 1'b1; c_corrupt = 1'b0;
            tick();
        end
        c_valid = 1'b0; c_ready = 1'b0;
        model_push({3'd7, 3'd0, 4'd6, 3'd4, addr, 1'b0});
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL bp_lat_n1 got=%b exp=0", rec_valid); end
        tick();
        checks++; if (rec_valid !== 1'b1) begin failures++; $display("FAIL bp_lat_n2 got=%b exp=1", rec_valid); end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_enable();
        send_msg(3'd7, 3'd0, 4'd6, 3'd1, 32'h100, 0, 1'b0, 1'b1, -1, -1, 10);
        send_msg(3'd7, 3'd3, 4'd6, 3'd2, 32'h200, 0, 1'b1, 1'b0, -1, -1, 10);
        send_msg(3'd4, 3'd0, 4'd0, 3'd3, 32'h300, 0, 1'b0, 1'b0, -1, -1, 0);
        enable = 1'b1;
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL enable_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL enable_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int round = 0; round < 5; round++) begin
            for (int m = 0; m < 5; m++) begin
                send_msg(3'($urandom), 3'($urandom), SIZE_W'($urandom_range(0, 7)), SOURCE_W'($urandom),
                         ADDR_W'($urandom), (($urandom_range(0, 3) == 0) ? $urandom : 32'h0),
                         1'($urandom_range(0, 3) != 0), 1'($urandom), -1, -1,
                         (($urandom_range(0, 1) == 1) ? 30 : 0));
            end
            drain();
            checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_rec got=%h exp=%h", got_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
        checks++; if ({overflow, proto_err, drop_count} !== {m_overflow, m_proto, CNT_W'(m_drop)}) begin
            failures++; $display("FAIL rand_status got=%b%b/%0d exp=%b%b/%0d", overflow, proto_err, drop_count, m_overflow, m_proto, m_drop);
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        for (int m = 0; m < 10; m++)
            send_msg(3'd4, 3'($urandom), 4'd6, SOURCE_W'($urandom), ADDR_W'($urandom), 0, 1'b1, 1'b1, -1, -1, 0);
        tick();
        checks++; if (drop_count !== CNT_W'(m_drop)) begin failures++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_count, m_drop); end
        checks++; if (overflow !== m_overflow) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, m_overflow); end
        void'(exp_q.pop_front());
        send_msg(3'd6, 3'd2, 4'd3, 3'd7, 32'hCAFE_0000, 0, 1'b1, 1'b1, -1, -1, 0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        tick();
        checks++; if (drop_count !== CNT_W'(m_drop)) begin failures++; $display("FAIL ovf_pushpop_drop got=%0d exp=%0d", drop_count, m_drop); end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_proto_err();
        send_msg(3'd7, 3'd0, 4'd6, 3'd2, 32'h0001_0000, 0, 1'b1, 1'b1, 2, -1, 20);
        tick();
        tick();
        checks++; if (proto_err !== m_proto) begin failures++; $display("FAIL proto_set got=%b exp=%b", proto_err, m_proto); end
        checks++; if (rec_valid !== 1'b1 || rec_address !== 32'h0001_0000) begin
            failures++; $display("FAIL proto_rec got=%b/%h exp=1/00010000", rec_valid, rec_address);
        end
        pulse_clear();
        checks++; if ({proto_err, overflow, drop_count, rec_valid} !== '0) begin
            failures++; $display("FAIL proto_clear got=%b%b/%0d/%b exp=00/0/0", proto_err, overflow, drop_count, rec_valid);
        end
    endtask

    task automatic test_clear();
        send_msg(3'd4, 3'd1, 4'd2, 3'd1, 32'h55, 0, 1'b1, 1'b1, -1, -1, 0);
        pulse_clear();
        tick();
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL clear_wins got=%b exp=0", rec_valid); end
        send_msg(3'd7, 3'd0, 4'd6, 3'd6, 32'h0777_0000, 32'h2, 1'b1, 1'b1, -1, 3, 20);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL clear_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL clear_mid_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_timestamp();
        send_msg(3'd4, 3'd0, 4'd3, 3'd1, 32'h10, 0, 1'b1, 1'b1, -1, -1, 0);
`ifdef TL_C_INSIGHT_TS_EN
        repeat (16) tick();
        send_msg(3'd4, 3'd0, 4'd3, 3'd2, 32'h20, 0, 1'b1, 1'b1, -1, -1, 0);
        drain();
        checks++; if (got_ts.size() !== 2) begin failures++; $display("FAIL ts_count got=%0d exp=2", got_ts.size()); end
        else begin
            checks++; if (got_ts[1] - got_ts[0] !== TS_W'(17)) begin failures++; $display("FAIL ts_delta got=%0d exp=17", got_ts[1] - got_ts[0]); end
        end
`else
        drain();
        checks++; if (got_ts.size() !== 1) begin failures++; $display("FAIL ts_count got=%0d exp=1", got_ts.size()); end
        else begin
            checks++; if (got_ts[0] !== '0) begin failures++; $display("FAIL ts_zero got=%h exp=0", got_ts[0]); end
        end
`endif
        exp_q.delete();
    endtask

    task automatic test_reset_midburst();
        enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            c_valid = 1'b1; c_ready = 1'b1; c_opcode = 3'd7; c_param = 3'd0; c_size = 4'd6;
            c_source = 3'd3; c_address = 32'hAA00; c_corrupt = 1'b0;
            tick();
        end
        c_valid = 1'b0; c_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        repeat (12) tick();
        checks++; if ({rec_valid, proto_err, drop_count} !== '0) begin
            failures++; $display("FAIL rst_mid_idle got=%b%b/%0d exp=00/0", rec_valid, proto_err, drop_count);
        end
        send_msg(3'd4, 3'd5, 4'd1, 3'd6, 32'h1234_5678, 0, 1'b1, 1'b1, -1, -1, 0);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid_rec got=%h exp=%h", got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst();
        test_backpressure();
        test_enable();
        test_random();
        test_overflow();
        test_proto_err();
        test_clear();
        test_timestamp();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
